// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a small
// load/fetch/halt controller, with internally synchronized reset release.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        programLoaded,
  input  logic [31:0] fullInstruction,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jumpTaken,
  input  logic [31:0] jumpTarget,
  output logic [31:0] toPC,
  output logic [31:0] IF_ID_instruction,
  output logic [31:0] IF_ID_pcPlus4,
  output logic        IF_ID_valid,
  output logic        halted,
  output logic [31:0] fetchCount
);

  typedef enum logic [1:0] {
    WAIT_LOAD = 2'd0,
    FETCH     = 2'd1,
    HALT      = 2'd2
  } fetch_state_t;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic [31:0]  count_q, count_d;
  logic [31:0]  pc_plus4;
  logic [1:0]   rst_sync_q;
  logic         rst_n_int;

  // Assertion is immediate; release is delayed two clocks so the first state
  // change lands no earlier than the second edge after reset goes high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];
  assign pc_plus4  = pc_q + 32'd4;

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= WAIT_LOAD;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      WAIT_LOAD: begin
        pc_d    = RESET_PC;
        valid_d = 1'b0;
        if (programLoaded) state_d = FETCH;
      end
      FETCH: begin
        // Losing the program outranks everything; redirects outrank halt.
        if (!programLoaded) begin
          state_d = WAIT_LOAD;
          pc_d    = RESET_PC;
          valid_d = 1'b0;
        end else if (branchTaken) begin
          pc_d    = {branchTarget[31:2], 2'b00};
          valid_d = 1'b0;
          instr_d = 32'd0;
        end else if (jumpTaken) begin
          pc_d    = {jumpTarget[31:2], 2'b00};
          valid_d = 1'b0;
          instr_d = 32'd0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (fullInstruction == HALT_WORD) begin
          state_d = HALT;
          valid_d = 1'b0;
        end else begin
          instr_d = fullInstruction;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          if (count_q != 32'hFFFFFFFF) count_d = count_q + 32'd1;
        end
      end
      HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = WAIT_LOAD;
        pc_d    = RESET_PC;
        valid_d = 1'b0;
      end
    endcase
  end

  assign toPC              = pc_q;
  assign IF_ID_instruction = instr_q;
  assign IF_ID_pcPlus4     = pc4_q;
  assign IF_ID_valid       = valid_q;
  assign halted            = (state_q == HALT);
  assign fetchCount        = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: load, stall, redirects, halt, wrap,
// load loss and asynchronous reset, checked with immediate assertions.
module tb_pc_fetch_unit;

  logic        clock;
  logic        reset;
  logic        programLoaded;
  logic [31:0] fullInstruction;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jumpTaken;
  logic [31:0] jumpTarget;
  logic [31:0] toPC;
  logic [31:0] IF_ID_instruction;
  logic [31:0] IF_ID_pcPlus4;
  logic        IF_ID_valid;
  logic        halted;
  logic [31:0] fetchCount;

  int checks;
  int failures;

  pc_fetch_unit dut (
    .clock            (clock),
    .reset            (reset),
    .programLoaded    (programLoaded),
    .fullInstruction  (fullInstruction),
    .stall            (stall),
    .branchTaken      (branchTaken),
    .branchTarget     (branchTarget),
    .jumpTaken        (jumpTaken),
    .jumpTarget       (jumpTarget),
    .toPC             (toPC),
    .IF_ID_instruction(IF_ID_instruction),
    .IF_ID_pcPlus4    (IF_ID_pcPlus4),
    .IF_ID_valid      (IF_ID_valid),
    .halted           (halted),
    .fetchCount       (fetchCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic ld, input logic [31:0] instr,
                               input logic stl, input logic br,
                               input logic [31:0] brT, input logic jp,
                               input logic [31:0] jpT);
    programLoaded   = ld;
    fullInstruction = instr;
    stall           = stl;
    branchTaken     = br;
    branchTarget    = brT;
    jumpTaken       = jp;
    jumpTarget      = jpT;
    stepCycle();
  endtask

  task automatic checkAllReset(input string tag);
    checkOutput({tag, "_toPC"},  toPC, 32'h0);
    checkOutput({tag, "_instr"}, IF_ID_instruction, 32'h0);
    checkOutput({tag, "_pc4"},   IF_ID_pcPlus4, 32'h0);
    checkOutput({tag, "_valid"}, {31'd0, IF_ID_valid}, 32'h0);
    checkOutput({tag, "_halted"},{31'd0, halted}, 32'h0);
    checkOutput({tag, "_count"}, fetchCount, 32'h0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    programLoaded = 1'b0;
    fullInstruction = 32'h0;
    stall = 1'b0;
    branchTaken = 1'b0;
    branchTarget = 32'h0;
    jumpTaken = 1'b0;
    jumpTarget = 32'h0;
    #1;
    checkAllReset("reset");
    stepCycle();
    stepCycle();

    // Release with program ready; state may not move before the third edge.
    reset = 1'b1;
    applyStimulus(1'b1, 32'h201d0100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    stepCycle();
    stepCycle();
    checkOutput("sync_valid", {31'd0, IF_ID_valid}, 32'h0);
    checkOutput("sync_toPC", toPC, 32'h0);

    applyStimulus(1'b1, 32'h201d0100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("load1_instr", IF_ID_instruction, 32'h201d0100);
    checkOutput("load1_pc4", IF_ID_pcPlus4, 32'h4);
    checkOutput("load1_valid", {31'd0, IF_ID_valid}, 32'h1);
    checkOutput("load1_toPC", toPC, 32'h4);
    applyStimulus(1'b1, 32'h2010000c, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("load2_instr", IF_ID_instruction, 32'h2010000c);
    checkOutput("load2_pc4", IF_ID_pcPlus4, 32'h8);
    checkOutput("load2_count", fetchCount, 32'd2);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h22100001, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("stall_toPC", toPC, 32'h8);
      checkOutput("stall_instr", IF_ID_instruction, 32'h2010000c);
      checkOutput("stall_pc4", IF_ID_pcPlus4, 32'h8);
      checkOutput("stall_count", fetchCount, 32'd2);
    end
    applyStimulus(1'b1, 32'h22100001, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("resume_instr", IF_ID_instruction, 32'h22100001);
    checkOutput("resume_pc4", IF_ID_pcPlus4, 32'hC);
    checkOutput("resume_count", fetchCount, 32'd3);
    applyStimulus(1'b1, 32'h00000020, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("seq16_toPC", toPC, 32'h10);

    // A halt word under a redirect must not halt.
    applyStimulus(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 1'b1, 32'hAC);
    checkOutput("jump_toPC", toPC, 32'hAC);
    checkOutput("jump_valid", {31'd0, IF_ID_valid}, 32'h0);
    checkOutput("jump_instr", IF_ID_instruction, 32'h0);
    checkOutput("jump_count", fetchCount, 32'd4);
    checkOutput("jump_nohalt", {31'd0, halted}, 32'h0);
    applyStimulus(1'b1, 32'h8c080000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("afterjump_valid", {31'd0, IF_ID_valid}, 32'h1);
    checkOutput("afterjump_pc4", IF_ID_pcPlus4, 32'hB0);
    checkOutput("afterjump_count", fetchCount, 32'd5);

    applyStimulus(1'b1, 32'h1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80);
    checkOutput("brjp_toPC", toPC, 32'h40);
    applyStimulus(1'b1, 32'h1, 1'b0, 1'b1, 32'h43, 1'b0, 32'h0);
    checkOutput("align_toPC", toPC, 32'h40);
    checkOutput("align_count", fetchCount, 32'd5);

    applyStimulus(1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hB8, 1'b0, 32'h0);
    checkOutput("brhalt_toPC", toPC, 32'hB8);
    checkOutput("brhalt_halted", {31'd0, halted}, 32'h0);
    applyStimulus(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("halt_halted", {31'd0, halted}, 32'h1);
    checkOutput("halt_valid", {31'd0, IF_ID_valid}, 32'h0);
    checkOutput("halt_count", fetchCount, 32'd5);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h12345678, 1'b0, (i == 3), 32'h100, (i == 5), 32'h200);
      checkOutput("halt_hold_toPC", toPC, 32'hB8);
      checkOutput("halt_hold_halted", {31'd0, halted}, 32'h1);
    end

    // Reset is the only way out of HALT and acts without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    checkAllReset("haltreset");
    stepCycle();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("restart_toPC", toPC, 32'h0);
    checkOutput("restart_valid", {31'd0, IF_ID_valid}, 32'h0);
    applyStimulus(1'b1, 32'h1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("restart_count", fetchCount, 32'd1);

    applyStimulus(1'b1, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFC);
    checkOutput("towrap_toPC", toPC, 32'hFFFFFFFC);
    applyStimulus(1'b1, 32'h2, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("wrap_toPC", toPC, 32'h0);
    checkOutput("wrap_pc4", IF_ID_pcPlus4, 32'h0);
    checkOutput("wrap_instr", IF_ID_instruction, 32'h2);
    checkOutput("wrap_count", fetchCount, 32'd2);

    applyStimulus(1'b1, 32'h3, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("preloss_toPC", toPC, 32'h4);
    applyStimulus(1'b0, 32'h3, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("loss_toPC", toPC, 32'h0);
    checkOutput("loss_valid", {31'd0, IF_ID_valid}, 32'h0);
    checkOutput("loss_count", fetchCount, 32'd3);
    applyStimulus(1'b0, 32'h3, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("waitload_count", fetchCount, 32'd3);
    applyStimulus(1'b1, 32'h3, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("reload_valid", {31'd0, IF_ID_valid}, 32'h0);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
    checkOutput("reload_redirect", toPC, 32'h20);
    applyStimulus(1'b1, 32'h5, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("reload_count", fetchCount, 32'd4);

    // Mid-FETCH reset with a redirect pending.
    jumpTaken = 1'b1;
    jumpTarget = 32'h300;
    #2;
    reset = 1'b0;
    #1;
    checkAllReset("midreset");
    stepCycle();
    checkAllReset("midreset_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, byte address of the first fetch after program load.
REQ-002 Parameter HALT_WORD, default 32'hFFFFFFFF, instruction encoding that halts fetch.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports as below.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 programLoaded  input  1  instruction memory holds a complete program.
REQ-007 fullInstruction  input  32  instruction word read at toPC, valid before the next rising edge.
REQ-008 stall  input  1  hazard stall from decode; hold PC and IF/ID contents.
REQ-009 branchTaken  input  1  redirect to branchTarget.
REQ-010 branchTarget  input  32  branch byte address.
REQ-011 jumpTaken  input  1  redirect to jumpTarget.
REQ-012 jumpTarget  input  32  jump or jr byte address.
REQ-013 toPC  output  32  current fetch byte address, driven to instruction memory.
REQ-014 IF_ID_instruction  output  32  registered fetched instruction.
REQ-015 IF_ID_pcPlus4  output  32  registered fetch address + 4.
REQ-016 IF_ID_valid  output  1  IF/ID register holds a real instruction.
REQ-017 halted  output  1  HALT state indicator.
REQ-018 fetchCount  output  32  instructions accepted into IF/ID.

Function
REQ-019 The FSM SHALL have three states: WAIT_LOAD, FETCH, HALT.
REQ-020 WAIT_LOAD: toPC = RESET_PC and IF_ID_valid = 0; on a rising edge with programLoaded = 1, go to FETCH.
REQ-021 FETCH, priority per edge: branchTaken, then jumpTaken, then stall, then sequential.
REQ-022 Branch or jump: PC <= target with bits [1:0] forced to 00; IF_ID_valid <= 0; IF_ID_instruction <= 0; fetchCount unchanged.
REQ-023 If branchTaken and jumpTaken are both high, branchTarget SHALL be used.
REQ-024 Stall with no redirect: PC, IF_ID_instruction, IF_ID_pcPlus4, IF_ID_valid and fetchCount all hold.
REQ-025 Sequential with fullInstruction != HALT_WORD:
  - IF_ID_instruction <= fullInstruction
  - IF_ID_pcPlus4 <= PC + 4
  - IF_ID_valid <= 1
  - PC <= PC + 4
  - fetchCount increments
REQ-026 Sequential with fullInstruction == HALT_WORD: go to HALT; PC holds; IF_ID_valid <= 0; fetchCount unchanged.
REQ-027 A redirect in the same cycle as HALT_WORD SHALL take the redirect and SHALL NOT halt.
REQ-028 PC + 4 SHALL wrap modulo 2^32, so 32'hFFFFFFFC is followed by 32'h00000000.
REQ-029 fetchCount SHALL saturate at 32'hFFFFFFFF.
REQ-030 HALT: halted = 1, PC frozen, IF_ID_valid = 0; the only exit from HALT is reset.
REQ-031 programLoaded falling in FETCH: next edge goes to WAIT_LOAD, PC <= RESET_PC, IF_ID_valid <= 0; fetchCount holds.
REQ-032 toPC SHALL be the PC register output directly, with no combinational path from any input.
REQ-033 Fetch latency: the instruction at address A SHALL appear in IF/ID one rising edge after toPC = A, provided there is no stall.

Reset
REQ-034 On reset low, asynchronously:
  - state = WAIT_LOAD
  - PC = RESET_PC
  - IF_ID_instruction = 0, IF_ID_pcPlus4 = 0, IF_ID_valid = 0
  - halted = 0, fetchCount = 0
REQ-035 Reset asserted mid-operation SHALL discard the in-flight fetch and any pending redirect.
REQ-036 Reset release SHALL be synchronized to clock internally; the first state change SHALL occur no earlier than the second rising edge after release.

Verification
REQ-037 Load then run: programLoaded high; memory returns 32'h201d0100 at 0 and 32'h2010000c at 4 -> IF/ID shows 201d0100/pcPlus4 4, then 2010000c/pcPlus4 8; fetchCount = 2.
REQ-038 Stall: stall held 3 cycles at toPC = 8 -> toPC stays 8, IF/ID unchanged, fetchCount unchanged; on release the fetch resumes at 8.
REQ-039 Redirect: jumpTaken with jumpTarget 32'hAC at PC 16 -> next toPC = 32'hAC, IF_ID_valid = 0 for one cycle; branch+jump together with branchTarget 32'h40 -> toPC = 32'h40; target 32'h43 -> toPC = 32'h40.
REQ-040 Halt: fullInstruction = 32'hFFFFFFFF at PC 32'hB8 -> halted = 1, toPC stays 32'hB8 for 10 cycles; the same word with branchTaken -> no halt.
REQ-041 Wrap: PC 32'hFFFFFFFC, sequential fetch -> toPC = 0, IF_ID_pcPlus4 = 0.
REQ-042 Reset and load loss: reset low mid-FETCH -> all outputs at reset values immediately; programLoaded low mid-run -> WAIT_LOAD, toPC = RESET_PC, fetchCount held.
